// File: rtl/iir_sched_pkg.sv
// Shared types and constants for the IIR band scheduler and its coefficient table.
package iir_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_OUTPUT
    } sched_state_e;

    typedef enum logic [2:0] {
        CFG_B1 = 3'd0,
        CFG_B2 = 3'd1,
        CFG_B3 = 3'd2,
        CFG_A2 = 3'd3,
        CFG_A3 = 3'd4
    } cfg_sel_e;

    localparam int unsigned COEF_MAX_W = 32;

    typedef struct packed {
        logic signed [COEF_MAX_W-1:0] b1;
        logic signed [COEF_MAX_W-1:0] b2;
        logic signed [COEF_MAX_W-1:0] b3;
        logic signed [COEF_MAX_W-1:0] a2;
        logic signed [COEF_MAX_W-1:0] a3;
    } coef_set_t;

    // Q1.16 unity passthrough: b1 = 1.0, everything else zero.
    localparam coef_set_t COEF_UNITY = '{
        b1: 32'sd65536,
        b2: '0,
        b3: '0,
        a2: '0,
        a3: '0
    };

endpackage

// File: rtl/iir_coef_table.sv
// Per-band biquad coefficient register file: one write port, one combinational read port.
module iir_coef_table
    import iir_sched_pkg::*;
#(
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned BAND_W    = 2
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              wr_en_i,
    input  logic [BAND_W-1:0] wr_band_i,
    input  logic [2:0]        wr_sel_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic [BAND_W-1:0] rd_band_i,
    output logic [COEF_W-1:0] rd_b1_o,
    output logic [COEF_W-1:0] rd_b2_o,
    output logic [COEF_W-1:0] rd_b3_o,
    output logic [COEF_W-1:0] rd_a2_o,
    output logic [COEF_W-1:0] rd_a3_o
);

    localparam logic signed [COEF_W-1:0] RST_B1 = COEF_W'(COEF_UNITY.b1);
    localparam logic signed [COEF_W-1:0] RST_B2 = COEF_W'(COEF_UNITY.b2);
    localparam logic signed [COEF_W-1:0] RST_B3 = COEF_W'(COEF_UNITY.b3);
    localparam logic signed [COEF_W-1:0] RST_A2 = COEF_W'(COEF_UNITY.a2);
    localparam logic signed [COEF_W-1:0] RST_A3 = COEF_W'(COEF_UNITY.a3);

    logic signed [COEF_W-1:0] b1_q [NUM_BANDS];
    logic signed [COEF_W-1:0] b2_q [NUM_BANDS];
    logic signed [COEF_W-1:0] b3_q [NUM_BANDS];
    logic signed [COEF_W-1:0] a2_q [NUM_BANDS];
    logic signed [COEF_W-1:0] a3_q [NUM_BANDS];

    logic wr_hit;
    assign wr_hit = wr_en_i && (int'(wr_band_i) < int'(NUM_BANDS));

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                b1_q[k] <= RST_B1;
                b2_q[k] <= RST_B2;
                b3_q[k] <= RST_B3;
                a2_q[k] <= RST_A2;
                a3_q[k] <= RST_A3;
            end
        end else if (wr_hit) begin
            // Reserved selects complete the handshake upstream but land nowhere.
            case (cfg_sel_e'(wr_sel_i))
                CFG_B1:  b1_q[wr_band_i] <= wr_data_i;
                CFG_B2:  b2_q[wr_band_i] <= wr_data_i;
                CFG_B3:  b3_q[wr_band_i] <= wr_data_i;
                CFG_A2:  a2_q[wr_band_i] <= wr_data_i;
                CFG_A3:  a3_q[wr_band_i] <= wr_data_i;
                default: ;
            endcase
        end
    end

    assign rd_b1_o = b1_q[rd_band_i];
    assign rd_b2_o = b2_q[rd_band_i];
    assign rd_b3_o = b3_q[rd_band_i];
    assign rd_a2_o = a2_q[rd_band_i];
    assign rd_a3_o = a3_q[rd_band_i];

endmodule

// File: rtl/iir_band_scheduler.sv
// Sequences NUM_BANDS cascaded biquad passes through one shared external biquad per sample.
// Optional IIR_SCHED_BYPASS_EN adds bypass_mask to skip selected bands.
module iir_band_scheduler
    import iir_sched_pkg::*;
#(
    parameter  int unsigned NUM_BANDS = 4,
    parameter  int unsigned COEF_W    = 18,
    parameter  int unsigned WDOG_CYC  = 255,
    localparam int unsigned BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              lrclk_posedge,
    input  logic              i_valid,
    input  logic [15:0]       audio_in,
    input  logic              cfg_wr,
    input  logic [BAND_W-1:0] cfg_band,
    input  logic [2:0]        cfg_sel,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              cfg_ready,
`ifdef IIR_SCHED_BYPASS_EN
    input  logic [NUM_BANDS-1:0] bypass_mask,
`endif
    output logic              biq_start,
    output logic [BAND_W-1:0] biq_band,
    output logic [15:0]       biq_x,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] b3,
    output logic [COEF_W-1:0] a2,
    output logic [COEF_W-1:0] a3,
    input  logic              biq_done,
    input  logic [15:0]       biq_y,
    output logic [15:0]       audio_out,
    output logic              o_valid,
    output logic              busy,
    output logic              overrun,
    output logic              wdog_err
);

    localparam int unsigned       WDOG_W    = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

    sched_state_e      state_q, state_d;
    logic [BAND_W-1:0] idx_q, idx_d, idx_inc;
    logic [15:0]       work_q, work_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [15:0]       audio_out_q;
    logic              o_valid_q, biq_start_q, busy_q, overrun_q, wdog_err_q;
    logic              strobe, wdog_hit, overrun_hit;
    logic              first_skip, next_skip;

    assign strobe  = lrclk_posedge && i_valid;
    assign idx_inc = idx_q + BAND_W'(1);

`ifdef IIR_SCHED_BYPASS_EN
    assign first_skip = bypass_mask[0];
    assign next_skip  = bypass_mask[idx_inc];
`else
    assign first_skip = 1'b0;
    assign next_skip  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        work_d      = work_q;
        wdog_d      = wdog_q;
        wdog_hit    = 1'b0;
        overrun_hit = strobe && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    work_d  = audio_in;
                    idx_d   = '0;
                    state_d = first_skip ? S_NEXT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result on the timeout cycle still wins over the watchdog.
                if (biq_done) begin
                    work_d  = biq_y;
                    state_d = S_NEXT;
                end else if (wdog_q == WDOG_LAST) begin
                    wdog_hit = 1'b1;
                    state_d  = S_NEXT;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_BAND) begin
                    state_d = S_OUTPUT;
                end else begin
                    idx_d   = idx_inc;
                    state_d = next_skip ? S_NEXT : S_ISSUE;
                end
            end
            S_OUTPUT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered off the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            work_q      <= '0;
            wdog_q      <= '0;
            audio_out_q <= '0;
            o_valid_q   <= 1'b0;
            biq_start_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            work_q      <= work_d;
            wdog_q      <= wdog_d;
            biq_start_q <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE);
            o_valid_q   <= (state_d == S_OUTPUT);
            if (state_d == S_OUTPUT) begin
                audio_out_q <= work_d;
            end
            overrun_q  <= overrun_q | overrun_hit;
            wdog_err_q <= wdog_err_q | wdog_hit;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);

    iir_coef_table #(
        .NUM_BANDS (NUM_BANDS),
        .COEF_W    (COEF_W),
        .BAND_W    (BAND_W)
    ) u_coef_table (
        .clk       (clk),
        .i_rst     (i_rst),
        .wr_en_i   (cfg_wr && cfg_ready),
        .wr_band_i (cfg_band),
        .wr_sel_i  (cfg_sel),
        .wr_data_i (cfg_data),
        .rd_band_i (idx_q),
        .rd_b1_o   (b1),
        .rd_b2_o   (b2),
        .rd_b3_o   (b3),
        .rd_a2_o   (a2),
        .rd_a3_o   (a3)
    );

    assign biq_start = biq_start_q;
    assign biq_band  = idx_q;
    assign biq_x     = work_q;
    assign audio_out = audio_out_q;
    assign o_valid   = o_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_iir_band_scheduler.sv
// Randomized bench for iir_band_scheduler with a behavioural biquad responder and cascade model.
module tb_iir_band_scheduler;

    localparam int unsigned NB = 4;
    localparam int unsigned CW = 18;
    localparam int unsigned WD = 255;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          lrclk_posedge;
    logic          i_valid;
    logic [15:0]   audio_in;
    logic          cfg_wr;
    logic [1:0]    cfg_band;
    logic [2:0]    cfg_sel;
    logic [CW-1:0] cfg_data;
    logic          cfg_ready;
    logic          biq_start;
    logic [1:0]    biq_band;
    logic [15:0]   biq_x;
    logic [CW-1:0] b1, b2, b3, a2, a3;
    logic          biq_done;
    logic [15:0]   biq_y;
    logic [15:0]   audio_out;
    logic          o_valid;
    logic          busy;
    logic          overrun;
    logic          wdog_err;
`ifdef IIR_SCHED_BYPASS_EN
    logic [NB-1:0] bypass_mask = '0;
`endif

    iir_band_scheduler #(
        .NUM_BANDS (NB),
        .COEF_W    (CW),
        .WDOG_CYC  (WD)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .lrclk_posedge (lrclk_posedge),
        .i_valid       (i_valid),
        .audio_in      (audio_in),
        .cfg_wr        (cfg_wr),
        .cfg_band      (cfg_band),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
`ifdef IIR_SCHED_BYPASS_EN
        .bypass_mask   (bypass_mask),
`endif
        .biq_start     (biq_start),
        .biq_band      (biq_band),
        .biq_x         (biq_x),
        .b1            (b1),
        .b2            (b2),
        .b3            (b3),
        .a2            (a2),
        .a3            (a3),
        .biq_done      (biq_done),
        .biq_y         (biq_y),
        .audio_out     (audio_out),
        .o_valid       (o_valid),
        .busy          (busy),
        .overrun       (overrun),
        .wdog_err      (wdog_err)
    );

    always #5 clk = ~clk;

    int unsigned   errors;
    int unsigned   checks;
    int            win;
    int            lat [NB];
    logic [CW-1:0] mtab [NB][5];
    logic [15:0]   exp_x;
    int            exp_band;
    int            nstarts, nvalid, valid_win, strobe_win, accept_win;
    logic [15:0]   valid_data;
    bit            pend;
    int            done_at;
    logic [15:0]   pend_x;
    int            pend_band;
    bit            echo, withhold, hold_wr, dbl_strobe, rst_mid, wr_done;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stand-in biquad transfer: identity in echo mode, otherwise a band-dependent scramble.
    function automatic logic [15:0] bq(input logic [15:0] x, input int b);
        if (echo) return x;
        return (x ^ 16'h3C5A) + 16'(b * 977 + 5);
    endfunction

    task automatic model_reset_table();
        for (int k = 0; k < int'(NB); k++) begin
            mtab[k][0] = CW'(65536);
            for (int s = 1; s < 5; s++) mtab[k][s] = '0;
        end
    endtask

    task automatic tick();
        bit hs;
        int k;
        hs = cfg_wr && cfg_ready;
        @(posedge clk);
        #1;
        win++;
        lrclk_posedge = 1'b0;
        i_valid       = 1'b0;
        if (hs) begin
            accept_win = win - 1;
            wr_done    = 1'b1;
            cfg_wr     = 1'b0;
            if (cfg_sel < 3'd5) mtab[cfg_band][cfg_sel] = cfg_data;
        end
        if (biq_start) begin
            k = exp_band % int'(NB);
            nstarts++;
            check_eq("start_band", 128'(biq_band), 128'(k));
            check_eq("start_x", 128'(biq_x), 128'(exp_x));
            check_eq("coef", 128'({b1, b2, b3, a2, a3}),
                     128'({mtab[k][0], mtab[k][1], mtab[k][2], mtab[k][3], mtab[k][4]}));
            pend      = 1'b1;
            pend_x    = biq_x;
            pend_band = int'(biq_band);
            done_at   = win + lat[biq_band];
            if (!(withhold && k == 0)) exp_x = bq(exp_x, k);
            exp_band++;
        end
        if (o_valid) begin
            nvalid++;
            valid_win  = win;
            valid_data = audio_out;
        end
        biq_done = 1'b0;
        if (pend && win == done_at && !(withhold && pend_band == 0)) begin
            biq_done = 1'b1;
            biq_y    = bq(pend_x, pend_band);
            pend     = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_audio_out"}, 128'(audio_out), 128'(0));
        check_eq({tag, "_biq_x"}, 128'(biq_x), 128'(0));
        check_eq({tag, "_o_valid"}, 128'(o_valid), 128'(0));
        check_eq({tag, "_biq_start"}, 128'(biq_start), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_overrun"}, 128'(overrun), 128'(0));
        check_eq({tag, "_wdog_err"}, 128'(wdog_err), 128'(0));
        check_eq({tag, "_band"}, 128'(biq_band), 128'(0));
        check_eq({tag, "_cfg_ready"}, 128'(cfg_ready), 128'(1));
        check_eq({tag, "_coef"}, 128'({b1, b2, b3, a2, a3}), 128'({CW'(65536), {(4 * CW) {1'b0}}}));
    endtask

    task automatic cfg_write(input int band, input int sel, input logic [CW-1:0] data);
        cfg_wr   = 1'b1;
        cfg_band = 2'(band);
        cfg_sel  = 3'(sel);
        cfg_data = data;
        wr_done  = 1'b0;
        for (int t = 0; t < 50 && !wr_done; t++) tick();
        check_eq("cfg_accept", 128'(wr_done), 128'(1));
        cfg_wr = 1'b0;
    endtask

    task automatic run_sample(input logic [15:0] x, input int budget);
        bit armed;
        int exp_lat;
        armed   = 1'b0;
        exp_lat = 2 * int'(NB) + 1;
        for (int k = 0; k < int'(NB); k++) exp_lat += (withhold && k == 0) ? int'(WD) : lat[k];
        exp_x     = x;
        exp_band  = 0;
        nstarts   = 0;
        nvalid    = 0;
        valid_win = -1;
        wr_done   = 1'b0;
        lrclk_posedge = 1'b1;
        i_valid       = 1'b1;
        audio_in      = x;
        strobe_win    = win;
        tick();
        audio_in = 16'($urandom);
        for (int t = 0; t < budget; t++) begin
            if (!armed && !biq_start && (hold_wr || rst_mid) && nstarts >= 2) begin
                armed = 1'b1;
                if (hold_wr) begin
                    check_eq("ready_in_wait", 128'(cfg_ready), 128'(0));
                    cfg_wr   = 1'b1;
                    cfg_band = 2'd1;
                    cfg_sel  = 3'd0;
                    cfg_data = CW'($urandom);
                end else begin
                    i_rst = 1'b1;
                    #1;
                    check_reset_state("mid_rst");
                    pend     = 1'b0;
                    biq_done = 1'b0;
                    model_reset_table();
                    tick();
                    i_rst = 1'b0;
                end
            end
            if (!armed && !biq_start && dbl_strobe && nstarts >= 1) begin
                armed         = 1'b1;
                lrclk_posedge = 1'b1;
                i_valid       = 1'b1;
                audio_in      = 16'($urandom);
            end
            tick();
            if (nvalid > 0 && win >= valid_win + 3) break;
        end
        if (rst_mid) begin
            check_eq("rst_no_valid", 128'(nvalid), 128'(0));
            check_eq("rst_no_start", 128'(nstarts), 128'(2));
        end else begin
            check_eq("valid_count", 128'(nvalid), 128'(1));
            check_eq("latency", 128'(valid_win - strobe_win), 128'(exp_lat));
            check_eq("audio_out", 128'(valid_data), 128'(exp_x));
            check_eq("start_count", 128'(nstarts), 128'(NB));
            if (hold_wr) check_eq("wr_accept_win", 128'(accept_win), 128'(valid_win + 1));
            if (dbl_strobe) check_eq("overrun", 128'(overrun), 128'(1));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        win    = 0;
        i_rst  = 1'b1;
        lrclk_posedge = 1'b0;
        i_valid  = 1'b0;
        audio_in = '0;
        cfg_wr   = 1'b0;
        cfg_band = '0;
        cfg_sel  = '0;
        cfg_data = '0;
        biq_done = 1'b0;
        biq_y    = '0;
        pend     = 1'b0;
        echo     = 1'b1;
        withhold = 1'b0;
        hold_wr  = 1'b0;
        dbl_strobe = 1'b0;
        rst_mid  = 1'b0;
        wr_done  = 1'b0;
        accept_win = -1;
        for (int k = 0; k < int'(NB); k++) lat[k] = 3;
        model_reset_table();

        repeat (3) tick();
        check_reset_state("por");
        i_rst = 1'b0;
        tick();

        run_sample(16'd1000, 400);

        cfg_write(2, 3, CW'(-30000));
        run_sample(16'($urandom), 400);

        echo = 1'b0;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < int'(NB); k++) lat[k] = int'($urandom_range(1, 6));
            biq_done = 1'b1;
            biq_y    = 16'($urandom);
            tick();
            check_eq("idle_done_busy", 128'(busy), 128'(0));
            if (it % 2 == 0) begin
                cfg_write(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 7)), CW'($urandom));
            end else begin
                cfg_wr   = 1'b1;
                cfg_band = 2'($urandom_range(0, NB - 1));
                cfg_sel  = 3'($urandom_range(0, 4));
                cfg_data = CW'($urandom);
            end
            run_sample(16'($urandom), 400);
            check_eq("wdog_quiet", 128'(wdog_err), 128'(0));
        end

        echo = 1'b1;
        for (int k = 0; k < int'(NB); k++) lat[k] = 3;
        hold_wr = 1'b1;
        run_sample(16'($urandom), 400);
        hold_wr = 1'b0;
        check_eq("overrun_quiet", 128'(overrun), 128'(0));

        dbl_strobe = 1'b1;
        run_sample(16'($urandom), 400);
        dbl_strobe = 1'b0;

        withhold = 1'b1;
        run_sample(16'($urandom), 600);
        withhold = 1'b0;
        check_eq("wdog_err", 128'(wdog_err), 128'(1));

        rst_mid = 1'b1;
        run_sample(16'($urandom), 60);
        rst_mid = 1'b0;

        echo = 1'b0;
        run_sample(16'($urandom), 400);
        check_eq("post_rst_overrun", 128'(overrun), 128'(0));
        check_eq("post_rst_wdog", 128'(wdog_err), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_band_scheduler.md
IIR_BAND_SCHEDULER -- requirements
Module: iir_band_scheduler

Interface
REQ-001 Parameter NUM_BANDS, default 4, sets the number of cascaded biquad bands sharing one datapath.
REQ-002 Parameter COEF_W, default 18, sets the signed coefficient width (Q1.16, 65536 = 1.0).
REQ-003 Parameter WDOG_CYC, default 255, sets the maximum cycles allowed between biq_start and biq_done.
REQ-004 clk  in  1  sole clock; every flop is clocked on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 lrclk_posedge  in  1  one-cycle sample strobe.
REQ-007 i_valid  in  1  qualifies audio_in on the strobe cycle.
REQ-008 audio_in  in  16  signed input sample.
REQ-009 cfg_wr  in  1  coefficient write request; held until accepted.
REQ-010 cfg_band  in  clog2(NUM_BANDS)  target band.
REQ-011 cfg_sel  in  3  coefficient select: 0=b1, 1=b2, 2=b3, 3=a2, 4=a3; 5-7 ignored.
REQ-012 cfg_data  in  COEF_W  signed coefficient value.
REQ-013 cfg_ready  out  1  write accepted on the cycle where cfg_wr and cfg_ready are both high.
REQ-014 biq_start  out  1  one-cycle start pulse to the shared biquad.
REQ-015 biq_band  out  clog2(NUM_BANDS)  state-slot index for the biquad.
REQ-016 biq_x  out  16  biquad input sample.
REQ-017 b1, b2, b3, a2, a3  out  COEF_W each  coefficients, held stable from biq_start through biq_done.
REQ-018 biq_done  in  1  one-cycle completion pulse.
REQ-019 biq_y  in  16  biquad result; valid when biq_done is high.
REQ-020 audio_out  out  16  cascade result.
REQ-021 o_valid  out  1  one-cycle pulse when audio_out updates.
REQ-022 busy  out  1  high in every state except IDLE.
REQ-023 overrun  out  1  sticky error flag.
REQ-024 wdog_err  out  1  sticky error flag.

Function
REQ-025 The FSM shall have the states IDLE, ISSUE, WAIT, NEXT and OUTPUT.
REQ-026 IDLE shall move to ISSUE when lrclk_posedge and i_valid are both high, latching audio_in as the working sample and setting the band index to 0.
REQ-027 ISSUE shall last one cycle and assert biq_start, with biq_x = working sample, biq_band = index and coefficients = table[index].
REQ-028 WAIT shall move to NEXT on biq_done, replacing the working sample with biq_y.
REQ-029 NEXT shall increment the index and go to ISSUE, or go to OUTPUT after the band NUM_BANDS-1.
REQ-030 OUTPUT shall register audio_out = working sample, pulse o_valid for one cycle, and return to IDLE.
REQ-031 Latency from the strobe to o_valid shall be the sum of the per-band biquad latencies plus 2*NUM_BANDS+1 cycles.
REQ-032 A strobe with i_valid arriving outside IDLE shall be dropped, set overrun, and leave the current sequence unaffected.
REQ-033 cfg_ready shall be high only in IDLE; a write held during a sequence shall be deferred until IDLE.
REQ-034 A write and a strobe in the same IDLE cycle shall commit the write first, so the new sample uses the new value.
REQ-035 cfg_sel values 5-7 shall be accepted (handshake completes) with no table change.
REQ-036 In WAIT, a cycle counter reaching WDOG_CYC shall set wdog_err and go to NEXT with the working sample unchanged.
REQ-037 A biq_done arriving outside WAIT shall be ignored.
REQ-038 Coefficients shall be passed through unmodified, with no arithmetic on samples in this block.

Reset
REQ-039 On i_rst, the FSM shall return to IDLE and the index to 0.
REQ-040 On i_rst, audio_out and biq_x shall be 0, and o_valid, biq_start, busy, overrun and wdog_err shall be 0.
REQ-041 On i_rst, every table entry shall be b1=65536 and b2=b3=a2=a3=0 (unity passthrough).
REQ-042 Reset asserted mid-sequence shall abort the sequence with no o_valid and no further biq_start.

Configuration
REQ-043 With IIR_SCHED_BYPASS_EN defined, an input bypass_mask[NUM_BANDS-1:0] shall exist, and a band whose bit is set shall skip ISSUE/WAIT (NEXT only, sample unchanged, no biq_start).
REQ-044 With IIR_SCHED_BYPASS_EN undefined, there shall be no port and every band shall be processed.

Structure
REQ-045 Package iir_sched_pkg shall hold the state enum, the cfg_sel encoding, the coefficient struct and the unity-reset constant.
REQ-046 The coefficient table shall be the sub-module iir_coef_table (register file, one write port, one combinational read port indexed by band).

Verification
REQ-047 Reset, then a strobe with audio_in=1000 and a 3-cycle biquad model echoing x: four biq_start pulses with b1=65536 each, then o_valid with audio_out=1000.
REQ-048 Write band 2 a2=-30000, then a strobe: on the third biq_start, biq_band=2 and a2=-30000, while the other bands show the reset values.
REQ-049 cfg_wr held from WAIT of band 1: cfg_ready stays low until IDLE, and the write is accepted the cycle after OUTPUT.
REQ-050 A second strobe during WAIT: overrun=1, exactly 4 biq_start pulses, and one o_valid.
REQ-051 biq_done withheld on band 0: wdog_err=1 after 255 cycles, the sequence completes, and audio_out=input.
REQ-052 i_rst pulsed during band 1 WAIT: all outputs return to reset values, no o_valid, and the next strobe runs normally.
